// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: E-stage issue/stall controller for the multiply/divide unit.
// Starts MULT/MULTU/DIV/DIVU, performs MTHI/MTLO writes, stalls D while a
// HI/LO-dependent instruction would collide with a running operation, returns
// HI/LO for MFHI/MFLO, records the busy latency of the last operation and
// raises a sticky error on handshake violations or an over-long busy window.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no operation in flight; starts and HI/LO writes accepted
// WAIT_ACK | start issued last cycle; unit must raise busy now
// RUN      | unit busy; counting busy cycles until busy drops
module muldiv_ctrl #(
  parameter int MAX_WAIT = 12,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       e_op,
  input  logic [31:0]      e_rs,
  input  logic [31:0]      e_rt,
  input  logic             d_md,
  input  logic             md_busy,
  input  logic [31:0]      md_hi,
  input  logic [31:0]      md_lo,
  output logic             md_start,
  output logic [1:0]       md_sel,
  output logic             md_w,
  output logic             md_wsel,
  output logic [31:0]      md_d1,
  output logic [31:0]      md_d2,
  output logic             stall_d,
  output logic [31:0]      e_mf_data,
  output logic [CNT_W-1:0] lat_last,
  output logic             md_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] lat_nxt;
  logic             err_nxt;
  logic             e_start, e_mt;

  assign e_start = (e_op == OP_MULT) || (e_op == OP_MULTU) ||
                   (e_op == OP_DIV)  || (e_op == OP_DIVU);
  assign e_mt    = (e_op == OP_MTHI) || (e_op == OP_MTLO);

  // Operands and write data go straight through; the unit only samples them
  // when md_start or md_w is high.
  assign md_d1 = e_rs;
  assign md_d2 = e_rt;

  // MFHI/MFLO read the unit's current HI/LO in the same cycle.
  always_comb begin
    e_mf_data = 32'd0;
    if (e_op == OP_MFHI)
      e_mf_data = md_hi;
    else if (e_op == OP_MFLO)
      e_mf_data = md_lo;
  end

  // Operation select decode, 00 for anything that is not a start.
  always_comb begin
    md_sel = 2'b00;
    case (e_op)
      OP_MULTU: md_sel = 2'b01;
      OP_DIV:   md_sel = 2'b10;
      OP_DIVU:  md_sel = 2'b11;
      default:  md_sel = 2'b00;
    endcase
  end

  assign md_wsel = (e_op == OP_MTHI);

  // State, busy counter, last latency and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_last <= '0;
      md_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lat_last <= lat_nxt;
      md_err   <= err_nxt;
    end
  end

  // Next-state, handshake outputs, stall and error detection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lat_nxt   = lat_last;
    err_nxt   = md_err;
    md_start  = 1'b0;
    md_w      = 1'b0;
    stall_d   = 1'b0;

    case (state)
      IDLE: begin
        md_start = e_start;
        md_w     = e_mt;
        stall_d  = d_md & e_start;
        if (e_start) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        stall_d = d_md;
        if (md_busy) begin
          cnt_nxt   = cnt + CNT_ONE;
          state_nxt = RUN;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RUN: begin
        stall_d = d_md & md_busy;
        if (md_busy) begin
          if (cnt != CNT_SAT)
            cnt_nxt = cnt + CNT_ONE;
          if (cnt == WAIT_LIM)
            err_nxt = 1'b1;
        end else begin
          lat_nxt   = cnt;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A start or HI/LO write while an operation is in flight is dropped.
    if ((state != IDLE) && (e_start || e_mt))
      err_nxt = 1'b1;

    // Handshake and stall are held quiet while reset is asserted.
    if (rst) begin
      md_start = 1'b0;
      md_w     = 1'b0;
      stall_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural multiply/divide unit and
// a scoreboard queue of expected MFHI/MFLO results.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  e_op;
  logic [31:0] e_rs, e_rt;
  logic        d_md;
  logic        md_busy;
  logic [31:0] md_hi, md_lo;
  logic        md_start;
  logic [1:0]  md_sel;
  logic        md_w, md_wsel;
  logic [31:0] md_d1, md_d2;
  logic        stall_d;
  logic [31:0] e_mf_data;
  logic [4:0]  lat_last;
  logic        md_err;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] sb_q[$];

  logic        no_ack;
  int          busy_ovr;
  int          u_cnt;
  logic [63:0] u_res;

  muldiv_ctrl #(.MAX_WAIT(12), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .e_op      (e_op),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .d_md      (d_md),
    .md_busy   (md_busy),
    .md_hi     (md_hi),
    .md_lo     (md_lo),
    .md_start  (md_start),
    .md_sel    (md_sel),
    .md_w      (md_w),
    .md_wsel   (md_wsel),
    .md_d1     (md_d1),
    .md_d2     (md_d2),
    .stall_d   (stall_d),
    .e_mf_data (e_mf_data),
    .lat_last  (lat_last),
    .md_err    (md_err)
  );

  always #5 clk = ~clk;

  // {hi, lo} result of the unit for a given select.
  function automatic logic [63:0] unit_calc(input logic [1:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int     ia, ib;
    longint la, lb;
    logic [63:0] r;
    ia = int'(a);
    ib = int'(b);
    la = ia;
    lb = ib;
    case (sel)
      2'b00:   r = la * lb;
      2'b01:   r = {32'd0, a} * {32'd0, b};
      2'b10:   r = {32'(ia % ib), 32'(ia / ib)};
      default: r = {a % b, a / b};
    endcase
    return r;
  endfunction

  // Behavioural unit: busy in cycles 1..N after the start edge, HI/LO land
  // together with busy falling; MTHI/MTLO writes land on the sampling edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_busy <= 1'b0;
      u_cnt   <= 0;
      md_hi   <= 32'd0;
      md_lo   <= 32'd0;
    end else if (u_cnt != 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) begin
        md_busy <= 1'b0;
        md_hi   <= u_res[63:32];
        md_lo   <= u_res[31:0];
      end
    end else if (md_start && !no_ack) begin
      md_busy <= 1'b1;
      u_res   <= unit_calc(md_sel, md_d1, md_d2);
      u_cnt   <= (busy_ovr != 0) ? busy_ovr : (md_sel[1] ? 10 : 5);
    end else if (md_w) begin
      if (md_wsel) md_hi <= md_d1;
      else         md_lo <= md_d1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue a start in E and follow it through the busy window.
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic dmd, input logic [1:0] sel, input int busy_n,
                       input string tag);
    e_op = op; e_rs = rs; e_rt = rt; d_md = dmd;
    @(negedge clk);
    chk($sformatf("%s_start", tag), 32'(md_start), 32'd1);
    chk($sformatf("%s_sel", tag), 32'(md_sel), 32'(sel));
    chk($sformatf("%s_stall0", tag), 32'(stall_d), 32'(dmd));
    chk($sformatf("%s_d1", tag), md_d1, rs);
    chk($sformatf("%s_d2", tag), md_d2, rt);
    next_cycle();
    e_op = 4'd0;
    for (int c = 1; c <= busy_n; c++) begin
      @(negedge clk);
      chk($sformatf("%s_stall%0d", tag, c), 32'(stall_d), 32'(dmd));
      chk($sformatf("%s_nostart%0d", tag, c), 32'(md_start), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk($sformatf("%s_release", tag), 32'(stall_d), 32'd0);
    next_cycle();
  endtask

  // MFHI/MFLO in E, compared against the oldest scoreboard entry.
  task automatic mf_read(input logic [3:0] op, input string tag);
    e_op = op; e_rs = 32'd0; e_rt = 32'd0; d_md = 1'b0;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s: observed=%h expected=<scoreboard empty>", tag, e_mf_data);
    end else begin
      chk(tag, e_mf_data, sb_q.pop_front());
    end
    chk({tag, "_nostall"}, 32'(stall_d), 32'd0);
    next_cycle();
    e_op = 4'd0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; e_op = 4'd0; d_md = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk({tag, "_err_clr"}, 32'(md_err), 32'd0);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; e_op = 4'd1; e_rs = 32'd0; e_rt = 32'd0; d_md = 1'b1;
    no_ack = 1'b0; busy_ovr = 0;

    // Reset: handshake and stall forced low, registers cleared.
    @(negedge clk);
    chk("rst_start", 32'(md_start), 32'd0);
    chk("rst_stall", 32'(stall_d), 32'd0);
    chk("rst_lat", 32'(lat_last), 32'd0);
    chk("rst_err", 32'(md_err), 32'd0);
    next_cycle();
    e_op = 4'd5;
    @(negedge clk);
    chk("rst_w", 32'(md_w), 32'd0);
    next_cycle();
    rst = 1'b0; e_op = 4'd0; d_md = 1'b0;
    next_cycle();

    // MULT -3 * 5 with MFLO waiting in D.
    sb_q.push_back(32'hFFFF_FFF1);
    sb_q.push_back(32'hFFFF_FFFF);
    issue(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b1, 2'b00, 5, "mult");
    chk("mult_lat", 32'(lat_last), 32'd5);
    mf_read(4'd8, "mult_lo");
    mf_read(4'd7, "mult_hi");
    chk("mult_err", 32'(md_err), 32'd0);

    // DIVU 100 / 7.
    sb_q.push_back(32'd14);
    sb_q.push_back(32'd2);
    issue(4'd4, 32'd100, 32'd7, 1'b1, 2'b11, 10, "divu");
    chk("divu_lat", 32'(lat_last), 32'd10);
    mf_read(4'd8, "divu_lo");
    mf_read(4'd7, "divu_hi");

    // DIV -7 / 2 with an unrelated op in D.
    sb_q.push_back(32'hFFFF_FFFD);
    sb_q.push_back(32'hFFFF_FFFF);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 2'b10, 10, "div");
    mf_read(4'd8, "div_lo");
    mf_read(4'd7, "div_hi");

    // MULTU 0xFFFFFFFF * 2 with an unrelated op in D.
    sb_q.push_back(32'hFFFF_FFFE);
    sb_q.push_back(32'd1);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 2'b01, 5, "multu");
    chk("multu_lat", 32'(lat_last), 32'd5);
    mf_read(4'd8, "multu_lo");
    mf_read(4'd7, "multu_hi");

    // MTHI then MFHI, MTLO then MFLO: no stall.
    e_op = 4'd5; e_rs = 32'hDEAD_BEEF; d_md = 1'b1;
    @(negedge clk);
    chk("mthi_w", 32'(md_w), 32'd1);
    chk("mthi_wsel", 32'(md_wsel), 32'd1);
    chk("mthi_stall", 32'(stall_d), 32'd0);
    chk("mthi_nostart", 32'(md_start), 32'd0);
    sb_q.push_back(32'hDEAD_BEEF);
    next_cycle();
    mf_read(4'd7, "mthi_read");
    e_op = 4'd6; e_rs = 32'h1234_5678; d_md = 1'b1;
    @(negedge clk);
    chk("mtlo_w", 32'(md_w), 32'd1);
    chk("mtlo_wsel", 32'(md_wsel), 32'd0);
    sb_q.push_back(32'h1234_5678);
    next_cycle();
    mf_read(4'd8, "mtlo_read");
    chk("mt_err", 32'(md_err), 32'd0);

    // Watchdog: unit holds busy for 20 cycles.
    busy_ovr = 20;
    e_op = 4'd1; e_rs = 32'd2; e_rt = 32'd3; d_md = 1'b0;
    @(negedge clk);
    chk("wd_start", 32'(md_start), 32'd1);
    next_cycle();
    e_op = 4'd0;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (k == 13) chk("wd_err_before", 32'(md_err), 32'd0);
      if (k == 14) chk("wd_err_set", 32'(md_err), 32'd1);
      if (k == 22) chk("wd_lat", 32'(lat_last), 32'd20);
      if (k == 23) chk("wd_err_sticky", 32'(md_err), 32'd1);
      next_cycle();
    end
    busy_ovr = 0;
    do_reset("wd");

    // Busy never rises: error and back to IDLE.
    no_ack = 1'b1;
    e_op = 4'd1; e_rs = 32'd4; e_rt = 32'd4; d_md = 1'b1;
    @(negedge clk);
    chk("nack_start", 32'(md_start), 32'd1);
    next_cycle();
    e_op = 4'd0;
    @(negedge clk);
    chk("nack_stall_wait", 32'(stall_d), 32'd1);
    next_cycle();
    e_op = 4'd6; e_rs = 32'h0000_AAAA;
    @(negedge clk);
    chk("nack_err", 32'(md_err), 32'd1);
    chk("nack_idle_w", 32'(md_w), 32'd1);
    chk("nack_stall_idle", 32'(stall_d), 32'd0);
    next_cycle();
    no_ack = 1'b0;
    do_reset("nack");

    // HI/LO write while busy is dropped and flagged.
    e_op = 4'd1; e_rs = 32'd3; e_rt = 32'd3; d_md = 1'b0;
    next_cycle();
    e_op = 4'd0;
    next_cycle();
    e_op = 4'd5; e_rs = 32'h1111_1111;
    @(negedge clk);
    chk("drop_w", 32'(md_w), 32'd0);
    chk("drop_start", 32'(md_start), 32'd0);
    next_cycle();
    e_op = 4'd0;
    @(negedge clk);
    chk("drop_err", 32'(md_err), 32'd1);
    for (int k = 0; k < 6; k++) next_cycle();
    do_reset("drop");

    // Reset in cycle 3 of a DIV, then a clean MULT.
    e_op = 4'd3; e_rs = 32'd50; e_rt = 32'd5; d_md = 1'b1;
    @(negedge clk);
    chk("rdiv_start", 32'(md_start), 32'd1);
    next_cycle();
    e_op = 4'd0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk($sformatf("rdiv_stall%0d", c), 32'(stall_d), 32'd1);
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rdiv_stall_rst", 32'(stall_d), 32'd0);
    next_cycle();
    rst = 1'b0;
    sb_q.push_back(32'd42);
    sb_q.push_back(32'd0);
    issue(4'd1, 32'd6, 32'd7, 1'b1, 2'b00, 5, "post_rst");
    chk("post_rst_lat", 32'(lat_last), 32'd5);
    mf_read(4'd8, "post_rst_lo");
    mf_read(4'd7, "post_rst_hi");
    chk("post_rst_err", 32'(md_err), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
